memory_game_ctrl: RTL and testbench

- Game-logic stage directly upstream of the VGA renderer in the memory card game.
- Conditions the three active-low push buttons (move_x, move_y, select) and owns the cursor position.
- Runs the flip/compare state machine for a 20-card, 10-pair board.
- Publishes per-card revealed/matched flags, cursor, score and win status for the renderer to draw each frame.

---
 rtl/memory_game_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_memory_game_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_ctrl.sv
// Game-logic controller for the 20-card memory game.
// Conditions the three push buttons, owns the cursor, runs the flip/compare
// sequence and publishes the per-card flags, score and win status that the
// VGA renderer draws every frame.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_FIRST   | waiting for the first card of a pair to be selected
// ST_SECOND  | one card face-up, waiting for a different valid card
// ST_COMPARE | single cycle: compare pair ids, score the attempt
// ST_HIDE    | mismatched pair stays face-up until the hide timer expires
// ST_WON     | all pairs matched; selects ignored until reset

module memory_game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HIDE_DELAY      = 25000000
) (
    input  logic         clock_25M,
    input  logic         reset_n,
    input  logic         move_x,
    input  logic         move_y,
    input  logic         select,
    input  logic [99:0]  card_order,
    output logic [4:0]   cursor_pos,
    output logic [19:0]  card_revealed,
    output logic [19:0]  card_matched,
    output logic [3:0]   pairs_found,
    output logic [7:0]   attempts,
    output logic         game_won
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HD_W = (HIDE_DELAY > 1) ? $clog2(HIDE_DELAY) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HIDE_LOAD = HD_W'(HIDE_DELAY - 1);

    typedef enum logic [2:0] {
        ST_FIRST   = 3'd0,
        ST_SECOND  = 3'd1,
        ST_COMPARE = 3'd2,
        ST_HIDE    = 3'd3,
        ST_WON     = 3'd4
    } state_t;

    // Button bit order throughout: [0] move_x, [1] move_y, [2] select.
    logic [2:0]      w_btn;
    logic [2:0]      r_sync_a;
    logic [2:0]      r_sync_b;
    logic [2:0]      r_deb;
    logic [2:0]      r_deb_d;
    logic [DB_W-1:0] r_db_cnt [3];
    logic [2:0]      w_press;

    state_t          r_state;
    state_t          w_next_state;

    logic [4:0]      r_cursor;
    logic [4:0]      r_first;
    logic [4:0]      r_second;
    logic [19:0]     r_revealed;
    logic [19:0]     r_matched;
    logic [3:0]      r_pairs;
    logic [7:0]      r_attempts;
    logic            r_game_won;
    logic [HD_W-1:0] r_hide_cnt;

    logic [4:0]      w_cur_after_y;
    logic [4:0]      w_cur_next;
    logic            w_sel_ok;
    logic            w_pair_eq;
    logic            w_do_first;
    logic            w_do_second;
    logic            w_do_match;
    logic            w_do_mismatch;
    logic            w_hide_done;

    // Pair id of every position; entries past 19 are never addressed but keep
    // the 5-bit index in range. The id LSB only distinguishes the two cards
    // of a pair and plays no part in matching.
    logic [3:0]      w_pair_id [32];
    logic [19:0]     w_unused_id_lsb;

    assign w_btn = {select, move_y, move_x};

    // Two-flop synchroniser plus per-button stability counter; the debounced
    // level only follows after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_a <= 3'b111;
            r_sync_b <= 3'b111;
            r_deb    <= 3'b111;
            r_deb_d  <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync_a <= w_btn;
            r_sync_b <= r_sync_a;
            r_deb_d  <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync_b[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_deb[i]    <= r_sync_b[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is the single cycle after the debounced level falls.
    assign w_press = r_deb_d & ~r_deb;

    function automatic logic [4:0] step_y(input logic [4:0] p);
        return (p[1:0] == 2'd3) ? (p - 5'd3) : (p + 5'd1);
    endfunction

    function automatic logic [4:0] step_x(input logic [4:0] p);
        return (p < 5'd4) ? (p + 5'd16) : (p - 5'd4);
    endfunction

    assign w_cur_after_y = w_press[1] ? step_y(r_cursor) : r_cursor;
    assign w_cur_next    = w_press[0] ? step_x(w_cur_after_y) : w_cur_after_y;

    // Cursor moves in every state, row step first then column step.
    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            r_cursor <= '0;
        end else begin
            r_cursor <= w_cur_next;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_pair_id
            if (g < 20) begin : g_card
                assign w_pair_id[g]       = card_order[5*g+1 +: 4];
                assign w_unused_id_lsb[g] = card_order[5*g];
            end else begin : g_pad
                assign w_pair_id[g] = '0;
            end
        end
    endgenerate

    // Select acts on the cursor as it was before any move in the same cycle.
    assign w_sel_ok  = w_press[2] & ~r_revealed[r_cursor] & ~r_matched[r_cursor];
    assign w_pair_eq = (w_pair_id[r_first] == w_pair_id[r_second]);

    // State register.
    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_next_state  = r_state;
        w_do_first    = 1'b0;
        w_do_second   = 1'b0;
        w_do_match    = 1'b0;
        w_do_mismatch = 1'b0;
        w_hide_done   = 1'b0;
        case (r_state)
            ST_FIRST: begin
                if (w_sel_ok) begin
                    w_do_first   = 1'b1;
                    w_next_state = ST_SECOND;
                end
            end
            ST_SECOND: begin
                // The first card is already revealed, so re-selecting it fails w_sel_ok.
                if (w_sel_ok) begin
                    w_do_second  = 1'b1;
                    w_next_state = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_pair_eq) begin
                    w_do_match   = 1'b1;
                    w_next_state = (r_pairs == 4'd9) ? ST_WON : ST_FIRST;
                end else begin
                    w_do_mismatch = 1'b1;
                    w_next_state  = ST_HIDE;
                end
            end
            ST_HIDE: begin
                if (r_hide_cnt == '0) begin
                    w_hide_done  = 1'b1;
                    w_next_state = ST_FIRST;
                end
            end
            ST_WON: begin
                w_next_state = ST_WON;
            end
            default: begin
                w_next_state = ST_FIRST;
            end
        endcase
    end

    // Card flags, score, hide timer and latched positions.
    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            r_first    <= '0;
            r_second   <= '0;
            r_revealed <= '0;
            r_matched  <= '0;
            r_pairs    <= '0;
            r_attempts <= '0;
            r_game_won <= 1'b0;
            r_hide_cnt <= '0;
        end else begin
            if (w_do_first) begin
                r_revealed[r_cursor] <= 1'b1;
                r_first              <= r_cursor;
            end
            if (w_do_second) begin
                r_revealed[r_cursor] <= 1'b1;
                r_second             <= r_cursor;
            end
            if (w_do_match || w_do_mismatch) begin
                if (r_attempts != 8'hFF) begin
                    r_attempts <= r_attempts + 8'd1;
                end
            end
            if (w_do_match) begin
                r_matched[r_first]   <= 1'b1;
                r_matched[r_second]  <= 1'b1;
                r_revealed[r_first]  <= 1'b0;
                r_revealed[r_second] <= 1'b0;
                r_pairs              <= r_pairs + 4'd1;
                if (r_pairs == 4'd9) begin
                    r_game_won <= 1'b1;
                end
            end
            if (w_do_mismatch) begin
                r_hide_cnt <= HIDE_LOAD;
            end
            if (r_state == ST_HIDE) begin
                if (w_hide_done) begin
                    r_revealed[r_first]  <= 1'b0;
                    r_revealed[r_second] <= 1'b0;
                end else begin
                    r_hide_cnt <= r_hide_cnt - HD_W'(1);
                end
            end
        end
    end

    assign cursor_pos    = r_cursor;
    assign card_revealed = r_revealed;
    assign card_matched  = r_matched;
    assign pairs_found   = r_pairs;
    assign attempts      = r_attempts;
    assign game_won      = r_game_won;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: button presses drive the DUT and a game-level
// model (row/column cursor, card sets, score) predicts the settled outputs.
module tb_memory_game_ctrl;

    localparam int DB = 4;
    localparam int HD = 8;

    logic         clock_25M = 1'b0;
    logic         reset_n   = 1'b0;
    logic         move_x    = 1'b1;
    logic         move_y    = 1'b1;
    logic         select    = 1'b1;
    logic [99:0]  card_order;
    logic [4:0]   cursor_pos;
    logic [19:0]  card_revealed;
    logic [19:0]  card_matched;
    logic [3:0]   pairs_found;
    logic [7:0]   attempts;
    logic         game_won;

    memory_game_ctrl #(.DEBOUNCE_CYCLES(DB), .HIDE_DELAY(HD)) dut (
        .clock_25M     (clock_25M),
        .reset_n       (reset_n),
        .move_x        (move_x),
        .move_y        (move_y),
        .select        (select),
        .card_order    (card_order),
        .cursor_pos    (cursor_pos),
        .card_revealed (card_revealed),
        .card_matched  (card_matched),
        .pairs_found   (pairs_found),
        .attempts      (attempts),
        .game_won      (game_won)
    );

    always #20 clock_25M = ~clock_25M;

    int ids [20] = '{7, 4, 16, 6, 18, 19, 5, 17, 2, 0, 10, 9, 12, 8, 11, 3, 1, 13, 15, 14};

    int n_checks = 0;
    int n_errors = 0;

    // Game-level model: phase 0 = first pick, 1 = second pick, 2 = won.
    int       m_pos;
    bit [19:0] m_rev;
    bit [19:0] m_match;
    int       m_pairs;
    int       m_att;
    bit       m_won;
    int       m_phase;
    int       m_first;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_rev = '0; m_match = '0; m_pairs = 0; m_att = 0;
        m_won = 1'b0; m_phase = 0; m_first = 0;
    endtask

    function automatic int model_move(input int pos, input bit mx, input bit my);
        int row, col;
        row = pos % 4;
        col = pos / 4;
        if (my) row = (row + 1) % 4;
        if (mx) col = (col == 0) ? 4 : col - 1;
        return col * 4 + row;
    endfunction

    function automatic int partner(input int p);
        for (int q = 0; q < 20; q++)
            if (q != p && ids[q] / 2 == ids[p] / 2) return q;
        return p;
    endfunction

    task automatic model_select(input int pos);
        if (m_phase == 0) begin
            if (!m_rev[pos] && !m_match[pos]) begin
                m_rev[pos] = 1'b1;
                m_first = pos;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!m_rev[pos] && !m_match[pos]) begin
                if (m_att < 255) m_att++;
                if (ids[m_first] / 2 == ids[pos] / 2) begin
                    m_match[m_first] = 1'b1;
                    m_match[pos] = 1'b1;
                    m_pairs++;
                    if (m_pairs == 10) begin
                        m_won = 1'b1;
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    m_phase = 0;
                end
                m_rev[m_first] = 1'b0;
                m_rev[pos] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        check_eq("cursor_pos", cursor_pos, m_pos);
        check_eq("card_revealed", card_revealed, m_rev);
        check_eq("card_matched", card_matched, m_match);
        check_eq("pairs_found", pairs_found, m_pairs);
        check_eq("attempts", attempts, m_att);
        check_eq("game_won", game_won, m_won);
    endtask

    // Hold the chosen buttons low for 'hold' clocks, release, and let the
    // release debounce (and any hide period) finish.
    task automatic press_raw(input bit mx, input bit my, input bit ps, input int hold);
        move_x = ~mx; move_y = ~my; select = ~ps;
        repeat (hold) @(negedge clock_25M);
        move_x = 1'b1; move_y = 1'b1; select = 1'b1;
        repeat (10) @(negedge clock_25M);
        if (ps) repeat (8) @(negedge clock_25M);
    endtask

    task automatic do_press(input bit mx, input bit my, input bit ps);
        press_raw(mx, my, ps, 6);
        if (ps) model_select(m_pos);
        m_pos = model_move(m_pos, mx, my);
        check_all();
    endtask

    task automatic navigate(input int tgt);
        for (int k = 0; k < 4 && (m_pos % 4) != (tgt % 4); k++) do_press(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5 && (m_pos / 4) != (tgt / 4); k++) do_press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock_25M);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clock_25M);
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit seen;
        bit done;
        int tgt;

        for (int p = 0; p < 20; p++) card_order[5*p +: 5] = 5'(ids[p]);
        model_reset();
        apply_reset();
        check_all();

        // Cursor wrap cases.
        do_press(1'b0, 1'b1, 1'b0);
        do_press(1'b0, 1'b1, 1'b0);
        do_press(1'b0, 1'b1, 1'b0);
        check_eq("at_pos3", cursor_pos, 3);
        do_press(1'b0, 1'b1, 1'b0);
        check_eq("row_wrap", cursor_pos, 0);
        do_press(1'b1, 1'b0, 1'b0);
        check_eq("col_wrap", cursor_pos, 16);
        do_press(1'b1, 1'b0, 1'b0);
        check_eq("col_step", cursor_pos, 12);
        navigate(2);
        do_press(1'b1, 1'b1, 1'b0);
        check_eq("wrap_xy", cursor_pos, 19);

        // Short glitch rejected, long press accepted exactly once.
        press_raw(1'b0, 1'b0, 1'b1, 3);
        check_eq("glitch_rejected", card_revealed, 20'h0);
        press_raw(1'b0, 1'b0, 1'b1, 10);
        model_select(m_pos);
        check_all();
        check_eq("one_event", card_revealed, 20'h80000);

        // Re-select first card in SECOND is ignored; partner completes the pair.
        do_press(1'b0, 1'b0, 1'b1);
        navigate(18);
        do_press(1'b0, 1'b0, 1'b1);
        check_eq("match_a", card_matched, 20'hC0000);

        // Matched card ignored in FIRST and in SECOND; then a second match.
        navigate(19);
        do_press(1'b0, 1'b0, 1'b1);
        navigate(1);
        do_press(1'b0, 1'b0, 1'b1);
        navigate(18);
        do_press(1'b0, 1'b0, 1'b1);
        navigate(6);
        do_press(1'b0, 1'b0, 1'b1);
        check_eq("match_b", card_matched, 20'hC0042);
        check_eq("attempts_2", attempts, 2);

        // Mismatch 0/2: both face-up for COMPARE plus HIDE_DELAY clocks.
        navigate(0);
        do_press(1'b0, 1'b0, 1'b1);
        navigate(2);
        select = 1'b0;
        cnt = 0; seen = 1'b0; done = 1'b0;
        for (int i = 1; i <= 80 && !done; i++) begin
            @(negedge clock_25M);
            if (i == 6) select = 1'b1;
            if (card_revealed == 20'h5) begin
                seen = 1'b1;
                cnt++;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        select = 1'b1;
        check_eq("hide_len", cnt, 1 + HD);
        check_eq("hide_cleared", card_revealed, 20'h0);
        model_select(m_pos);
        repeat (16) @(negedge clock_25M);
        check_all();

        // Mismatch 2/3 with a further select landing inside HIDE.
        do_press(1'b0, 1'b0, 1'b1);
        navigate(3);
        select = 1'b0; repeat (4) @(negedge clock_25M);
        select = 1'b1; repeat (4) @(negedge clock_25M);
        select = 1'b0; repeat (4) @(negedge clock_25M);
        select = 1'b1; repeat (30) @(negedge clock_25M);
        model_select(m_pos);
        check_all();
        check_eq("hide_sel_ignored", card_revealed, 20'h0);

        // Random play to the end of the game.
        for (int it = 0; it < 300 && !m_won; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                if (m_phase == 1 && $urandom_range(0, 2) != 0) tgt = partner(m_first);
                else tgt = int'($urandom_range(0, 19));
                navigate(tgt);
                do_press(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b1);
            end
        end
        check_eq("final_won", game_won, 1);
        check_eq("final_pairs", pairs_found, 10);
        check_eq("final_matched", card_matched, 20'hFFFFF);

        // WON: selects ignored, cursor still moves.
        do_press(1'b0, 1'b0, 1'b1);
        do_press(1'b1, 1'b1, 1'b0);

        // Reset in the middle of HIDE clears everything at once.
        apply_reset();
        check_all();
        navigate(0);
        do_press(1'b0, 1'b0, 1'b1);
        navigate(2);
        select = 1'b0;
        for (int i = 1; i <= 40 && card_revealed != 20'h5; i++) begin
            @(negedge clock_25M);
            if (i == 6) select = 1'b1;
        end
        select = 1'b1;
        check_eq("reveal_wait", card_revealed, 20'h5);
        repeat (3) @(negedge clock_25M);
        reset_n = 1'b0;
        #1;
        check_eq("rst_cursor", cursor_pos, 0);
        check_eq("rst_revealed", card_revealed, 0);
        check_eq("rst_matched", card_matched, 0);
        check_eq("rst_pairs", pairs_found, 0);
        check_eq("rst_attempts", attempts, 0);
        check_eq("rst_won", game_won, 0);
        repeat (2) @(negedge clock_25M);
        reset_n = 1'b1;
        model_reset();
        repeat (20) @(negedge clock_25M);
        check_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
